// File: rtl/switch_out_port_q.sv
// Per-egress-port FIFO stage between the switch fabric and the port consumers.
// Optional per-port full-drop counters are enabled with SWITCH_OUT_DROP_CNT_EN.
module switch_out_port_q #(
    parameter int N_PORTS = 4,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 8,
    parameter int PORT_W  = $clog2(N_PORTS),
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [PORT_W-1:0]          in_port,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_drop,
    output logic [N_PORTS-1:0]         port_full,
    output logic [N_PORTS*CNT_W-1:0]   port_level,
    output logic [N_PORTS*DATA_W-1:0]  port_out,
`ifdef SWITCH_OUT_DROP_CNT_EN
    output logic [N_PORTS*16-1:0]      drop_cnt,
`endif
    output logic [N_PORTS-1:0]         port_ready,
    input  logic [N_PORTS-1:0]         port_read
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PORT_W:0] N_PORTS_V = (PORT_W + 1)'(N_PORTS);

    logic [DATA_W-1:0] mem    [N_PORTS][DEPTH];
    logic [PTR_W-1:0]  wr_ptr [N_PORTS];
    logic [PTR_W-1:0]  rd_ptr [N_PORTS];
    logic [CNT_W-1:0]  level  [N_PORTS];

    logic [N_PORTS-1:0] wr_hit;
    logic [N_PORTS-1:0] rd_hit;
    logic [N_PORTS-1:0] full_drop;
    logic               in_range;

    assign in_range = {1'b0, in_port} < N_PORTS_V;

    always_comb begin
        port_full  = '0;
        port_ready = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            port_full[p]  = (level[p] == CNT_W'(DEPTH));
            port_ready[p] = (level[p] != '0);
        end
    end

    // Full is the pre-edge value, so a write to a full port is dropped even if it is popped now.
    always_comb begin
        wr_hit    = '0;
        rd_hit    = '0;
        full_drop = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            full_drop[p] = in_valid && in_range && (in_port == PORT_W'(p)) && port_full[p];
            wr_hit[p]    = in_valid && in_range && (in_port == PORT_W'(p)) && !port_full[p];
            rd_hit[p]    = port_read[p] && port_ready[p];
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < N_PORTS; p++) begin
            if (wr_hit[p]) mem[p][wr_ptr[p]] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_drop <= 1'b0;
            for (int p = 0; p < N_PORTS; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
                level[p]  <= '0;
            end
        end else begin
            in_drop <= in_valid && (!in_range || (|full_drop));
            for (int p = 0; p < N_PORTS; p++) begin
                if (wr_hit[p]) wr_ptr[p] <= wr_ptr[p] + PTR_W'(1);
                if (rd_hit[p]) rd_ptr[p] <= rd_ptr[p] + PTR_W'(1);
                case ({wr_hit[p], rd_hit[p]})
                    2'b10:   level[p] <= level[p] + CNT_W'(1);
                    2'b01:   level[p] <= level[p] - CNT_W'(1);
                    default: level[p] <= level[p];
                endcase
            end
        end
    end

    always_comb begin
        port_level = '0;
        port_out   = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            port_level[p*CNT_W +: CNT_W] = level[p];
            if (port_ready[p]) port_out[p*DATA_W +: DATA_W] = mem[p][rd_ptr[p]];
        end
    end

`ifdef SWITCH_OUT_DROP_CNT_EN
    logic [15:0] dcnt [N_PORTS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < N_PORTS; p++) dcnt[p] <= '0;
        end else begin
            for (int p = 0; p < N_PORTS; p++) begin
                if (full_drop[p] && (dcnt[p] != 16'hFFFF)) dcnt[p] <= dcnt[p] + 16'd1;
            end
        end
    end

    always_comb begin
        drop_cnt = '0;
        for (int p = 0; p < N_PORTS; p++) drop_cnt[p*16 +: 16] = dcnt[p];
    end
`endif

endmodule

// File: tb/tb_switch_out_port_q.sv
// Directed bench for switch_out_port_q: default 4-port instance plus a 5-port
// instance for out-of-range destination handling.
module tb_switch_out_port_q;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [1:0]  in_port;
    logic [7:0]  in_data;
    logic        in_drop;
    logic [3:0]  port_full;
    logic [15:0] port_level;
    logic [31:0] port_out;
    logic [3:0]  port_ready;
    logic [3:0]  port_read;

    logic        in_valid5;
    logic [2:0]  in_port5;
    logic        in_drop5;
    logic [4:0]  port_full5;
    logic [19:0] port_level5;
    logic [39:0] port_out5;
    logic [4:0]  port_ready5;
    logic [4:0]  port_read5;

`ifdef SWITCH_OUT_DROP_CNT_EN
    logic [63:0] drop_cnt;
    logic [79:0] drop_cnt5;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    switch_out_port_q u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_port    (in_port),
        .in_data    (in_data),
        .in_drop    (in_drop),
        .port_full  (port_full),
        .port_level (port_level),
        .port_out   (port_out),
`ifdef SWITCH_OUT_DROP_CNT_EN
        .drop_cnt   (drop_cnt),
`endif
        .port_ready (port_ready),
        .port_read  (port_read)
    );

    switch_out_port_q #(.N_PORTS(5)) u_dut5 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid5),
        .in_port    (in_port5),
        .in_data    (in_data),
        .in_drop    (in_drop5),
        .port_full  (port_full5),
        .port_level (port_level5),
        .port_out   (port_out5),
`ifdef SWITCH_OUT_DROP_CNT_EN
        .drop_cnt   (drop_cnt5),
`endif
        .port_ready (port_ready5),
        .port_read  (port_read5)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] p, input logic [7:0] d);
        in_valid = 1'b1;
        in_port  = p;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_port   = '0;
        in_data   = '0;
        port_read = '0;
        in_valid5 = 1'b0;
        in_port5  = '0;
        port_read5 = '0;
        repeat (2) step();
        rst = 1'b0;
        step();
        check("rst_ready", port_ready, 4'b0000);
        check("rst_level", port_level, 16'h0);
        check("rst_out",   port_out, 32'h0);
        check("rst_full",  port_full, 4'b0000);
        check("rst_drop",  in_drop, 1'b0);

        // single word through port 2
        push(2'd2, 8'hA5);
        check("single_ready", port_ready, 4'b0100);
        check("single_out",   port_out[23:16], 8'hA5);
        check("single_level", port_level[11:8], 4'd1);
        port_read = 4'b0100;
        step();
        port_read = '0;
        check("single_pop_ready", port_ready, 4'b0000);
        check("single_pop_out",   port_out, 32'h0);

        // asynchronous reset while a word is queued
        push(2'd1, 8'h3C);
        check("pre_arst_ready", port_ready, 4'b0010);
        #2 rst = 1'b1;
        #1;
        check("arst_ready", port_ready, 4'b0000);
        check("arst_level", port_level, 16'h0);
        check("arst_out",   port_out, 32'h0);
        step();
        rst = 1'b0;
        step();
        check("post_arst_ready", port_ready, 4'b0000);

        // fill port 0 past capacity
        for (int i = 1; i <= 9; i++) begin
            push(2'd0, 8'(i));
            if (i == 8) begin
                check("fill_full",  port_full, 4'b0001);
                check("fill_level", port_level[3:0], 4'd8);
                check("fill_nodrop", in_drop, 1'b0);
            end
        end
        check("ovf_drop",  in_drop, 1'b1);
        check("ovf_level", port_level[3:0], 4'd8);
`ifdef SWITCH_OUT_DROP_CNT_EN
        check("ovf_dcnt", drop_cnt[15:0], 16'd1);
`endif
        step();
        check("ovf_drop_1cyc", in_drop, 1'b0);
        port_read = 4'b0001;
        for (int i = 1; i <= 8; i++) begin
            check("drain0", port_out[7:0], 8'(i));
            step();
        end
        port_read = '0;
        check("drain0_level", port_level[3:0], 4'd0);
        check("drain0_ready", port_ready, 4'b0000);

        // full port 1 with simultaneous write and read
        for (int i = 0; i < 8; i++) push(2'd1, 8'h10 + 8'(i));
        check("p1_full", port_full, 4'b0010);
        in_valid  = 1'b1;
        in_port   = 2'd1;
        in_data   = 8'hFF;
        port_read = 4'b0010;
        step();
        in_valid  = 1'b0;
        port_read = '0;
        check("simfull_drop",  in_drop, 1'b1);
        check("simfull_level", port_level[7:4], 4'd7);
        check("simfull_head",  port_out[15:8], 8'h11);
`ifdef SWITCH_OUT_DROP_CNT_EN
        check("simfull_dcnt", drop_cnt[31:16], 16'd1);
`endif
        port_read = 4'b0010;
        for (int i = 1; i < 8; i++) begin
            check("drain1", port_out[15:8], 8'h10 + 8'(i));
            step();
        end
        port_read = '0;
        check("drain1_level", port_level[7:4], 4'd0);

        // wrap on port 3 at steady level 3 while ports 0..2 drain in parallel
        for (int k = 0; k < 3; k++) push(2'd0, 8'h40 + 8'(k));
        for (int k = 0; k < 3; k++) push(2'd1, 8'h50 + 8'(k));
        for (int k = 0; k < 3; k++) push(2'd2, 8'h60 + 8'(k));
        for (int k = 0; k < 3; k++) push(2'd3, 8'h80 + 8'(k));
        check("wrap_pre_level", port_level, 16'h3333);
        for (int i = 0; i < 20; i++) begin
            in_valid  = 1'b1;
            in_port   = 2'd3;
            in_data   = 8'h83 + 8'(i);
            port_read = (i < 3) ? 4'b1111 : 4'b1000;
            check("wrap_p3", port_out[31:24], 8'h80 + 8'(i));
            if (i < 3) begin
                check("par_p0", port_out[7:0],   8'h40 + 8'(i));
                check("par_p1", port_out[15:8],  8'h50 + 8'(i));
                check("par_p2", port_out[23:16], 8'h60 + 8'(i));
            end
            step();
        end
        in_valid  = 1'b0;
        port_read = '0;
        check("wrap_level", port_level, 16'h3000);
        port_read = 4'b1000;
        for (int i = 20; i < 23; i++) begin
            check("wrap_tail", port_out[31:24], 8'h80 + 8'(i));
            step();
        end
        port_read = '0;
        check("wrap_empty", port_ready, 4'b0000);

        // empty-port read is ignored
        port_read = 4'b0001;
        step();
        port_read = '0;
        check("empty_rd_level", port_level, 16'h0);
        check("empty_rd_ready", port_ready, 4'b0000);
        check("empty_rd_drop",  in_drop, 1'b0);

        // out-of-range destination on the 5-port instance
        in_valid5 = 1'b1;
        in_port5  = 3'd5;
        in_data   = 8'h77;
        step();
        in_valid5 = 1'b0;
        check("bad_dst_drop",  in_drop5, 1'b1);
        check("bad_dst_level", port_level5, 20'h0);
`ifdef SWITCH_OUT_DROP_CNT_EN
        check("bad_dst_dcnt", drop_cnt5, 80'h0);
`endif
        in_valid5 = 1'b1;
        in_port5  = 3'd4;
        in_data   = 8'hC4;
        step();
        in_valid5 = 1'b0;
        check("p4_drop",  in_drop5, 1'b0);
        check("p4_ready", port_ready5, 5'b10000);
        check("p4_out",   port_out5[39:32], 8'hC4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/switch_out_port_q.md
Name: switch_out_port_q

Overview:
- Parametrised output-port stage of the switch: one FIFO per egress port between the switch fabric and the external port consumers.
- Fabric pushes one DATA_W word per cycle, tagged with a destination port.
- Each egress port presents its head word with a port_ready / port_read handshake.
- Generalises the single 8-bit output port to N_PORTS ports with configurable width and buffer depth.

Parameters:
- N_PORTS, 4, number of egress ports (≥2).
- DATA_W, 8, word width in bits.
- DEPTH, 8, FIFO entries per port (power of 2, ≥2).
- PORT_W, $clog2(N_PORTS), width of in_port (derived).
- CNT_W, $clog2(DEPTH+1), width of a per-port level (derived).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  fabric write strobe.
- in_port  input  PORT_W  destination port of the write.
- in_data  input  DATA_W  write data.
- in_drop  output  1  registered pulse: previous-cycle write was discarded.
- port_full  output  N_PORTS  per-port FIFO full, registered.
- port_level  output  N_PORTS*CNT_W  per-port occupancy, registered; port p occupies bits [p*CNT_W +: CNT_W].
- port_out  output  N_PORTS*DATA_W  per-port head word; port p occupies bits [p*DATA_W +: DATA_W].
- port_ready  output  N_PORTS  per-port head word is valid.
- port_read  input  N_PORTS  per-port pop request from the consumer.

Behaviour:
- Reset (async, rst=1):
  - All read/write pointers and levels go to 0.
  - port_ready=0, port_full=0, port_level=0, port_out=0, in_drop=0.
  - FIFO storage contents are don't-care.
  - An asserted rst mid-operation discards all queued words immediately; there is no flush handshake.
- Write (accepted) at the posedge where all of the following hold:
  - in_valid=1;
  - in_port<N_PORTS;
  - port_full[in_port]=0 as seen before that edge.
- On an accepted write:
  - in_data is stored at wr_ptr[in_port];
  - wr_ptr[in_port] increments modulo DEPTH;
  - level increments.
- Write (dropped) when in_valid=1 and either in_port≥N_PORTS or the target port is full.
  - Storage and pointers are unchanged.
  - in_drop=1 for exactly the next cycle.
- Full port with simultaneous write and read on the same edge: the write is dropped (full is sampled pre-edge) and the read still pops. Level decrements by 1.
- Read on port p at the posedge where port_read[p]=1 and port_ready[p]=1:
  - rd_ptr[p] increments modulo DEPTH;
  - level decrements.
- port_read[p] while port_ready[p]=0 is ignored; no underflow.
- Non-full port with simultaneous write and read on the same edge: both take effect and the level is unchanged.
- Outputs:
  - port_ready[p] = (level[p]!=0).
  - port_out[p] = mem[p][rd_ptr[p]] when ready, otherwise 0.
  - port_full[p] = (level[p]==DEPTH).
- Latency: a word written at edge k into an empty port is visible on port_out/port_ready after edge k; the consumer may pop it at edge k+1.
- Ordering: strict FIFO per port; ports are fully independent. Reads on different ports in the same cycle are all honoured.
- Pointer wrap: pointers are PORT-local and wrap from DEPTH-1 to 0. Full and empty are distinguished by level, not by pointer equality.

Optional Feature:
- Macro: SWITCH_OUT_DROP_CNT_EN.
- When defined:
  - Adds output drop_cnt, N_PORTS*16 bits, one saturating 16-bit counter per port.
  - A counter increments on each write dropped because its port was full.
  - The counter saturates at 16'hFFFF and is cleared by rst.
  - Out-of-range in_port drops only pulse in_drop and do not increment any counter.
- When undefined:
  - The drop_cnt port and its counters are absent.
  - All other behaviour is identical.

Test Plan:
- Reset then idle:
  - Assert rst mid-cycle.
  - Required: all outputs 0 immediately (asynchronously); port_ready=4'b0000 after release.
- Single word:
  - Write in_port=2, in_data=8'hA5.
  - Next cycle: port_ready=4'b0100, port_out[2]=8'hA5, port_level[2]=1.
  - Pulse port_read[2]: port_ready[2]=0 and port_out[2]=0 next cycle.
- Fill and overflow:
  - Write 9 words 8'h01..8'h09 to port 0 with DEPTH=8.
  - port_full[0]=1 after the 8th write; the 9th write produces in_drop=1 and drop_cnt[0]=1 (macro on).
  - Draining yields 01..08 in order.
- Simultaneous at full:
  - Port 1 full; in the same cycle write 8'hFF to port 1 and set port_read[1]=1.
  - Required: write dropped, level=7, head advanced, 8'hFF never appears.
- Pointer wrap and concurrency:
  - Interleave 20 writes/reads on port 3 at steady level 3 while popping ports 0–2 in parallel.
  - Required: data in order across the wrap, no cross-port corruption.
- Bad destination and empty read:
  - in_port=3'd5 with N_PORTS=5 → in_drop=1 and no level changes.
  - port_read on an empty port → no change, level stays 0.
